ascii_hex_stream_parser: RTL and testbench

Byte-stream successor of the fixed 4-character ASCII-to-hex converter. Accepts ASCII characters one at a time over a valid/ready handshake (typically from the UART receive path) and accumulates up to NDIG hex digits, most significant first, into a NDIG*4-bit word. Delimiters end short words. Invalid characters produce an error word, then resynchronise on the next delimiter. Output is a valid/ready word stream toward the command/register layer.

---
 rtl/ascii_hex_stream_parser.sv | 154 +++++++++++++++
 tb/tb_ascii_hex_stream_parser.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_stream_parser.sv
// ASCII hex character stream to word parser with valid/ready on both sides.
// Digits accumulate MSB first; delimiters close short words; invalid characters emit an error word and then flush.
module ascii_hex_stream_parser #(
  parameter int NDIG        = 4,
  parameter bit ALLOW_LOWER = 1'b1,
  parameter int CW          = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_data,
  output logic [CW-1:0]     out_cnt,
  output logic              out_err
);

  localparam int W = 4 * NDIG;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic            flush;

  logic            is_digit;
  logic            is_delim;
  logic [3:0]      nibble;
  logic [W-1:0]    next_acc;
  logic [CW-1:0]   next_cnt;
  logic            accept;

  assign in_ready = !rst && (state != EMIT);
  assign accept   = in_valid && in_ready;
  assign next_cnt = cnt + CW'(1);

  generate
    if (NDIG == 1) begin : g_single
      assign next_acc = nibble;
    end else begin : g_multi
      assign next_acc = {acc[W-5:0], nibble};
    end
  endgenerate

  // Character classification: hex digit value, delimiter, or invalid.
  always_comb begin
    is_digit = 1'b0;
    is_delim = 1'b0;
    nibble   = 4'h0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = in_data[3:0];
    end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = in_data[3:0] + 4'd9;
    end else if (ALLOW_LOWER && in_data >= 8'h61 && in_data <= 8'h66) begin
      is_digit = 1'b1;
      nibble   = in_data[3:0] + 4'd9;
    end else if (in_data == 8'h0D || in_data == 8'h0A || in_data == 8'h20) begin
      is_delim = 1'b1;
    end else begin
      is_digit = 1'b0;
      is_delim = 1'b0;
    end
  end

  // Parser FSM: collect digits, hold a word until taken, discard up to a delimiter after errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      acc       <= '0;
      cnt       <= '0;
      flush     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (is_digit) begin
              if (next_cnt == CW'(NDIG)) begin
                out_data  <= next_acc;
                out_cnt   <= next_cnt;
                out_err   <= 1'b0;
                out_valid <= 1'b1;
                flush     <= 1'b0;
                acc       <= '0;
                cnt       <= '0;
                state     <= EMIT;
              end else begin
                acc <= next_acc;
                cnt <= next_cnt;
              end
            end else if (is_delim) begin
              // A delimiter with nothing collected is just spacing.
              if (cnt != '0) begin
                out_data  <= acc;
                out_cnt   <= cnt;
                out_err   <= 1'b0;
                out_valid <= 1'b1;
                flush     <= 1'b0;
                acc       <= '0;
                cnt       <= '0;
                state     <= EMIT;
              end else begin
                state <= COLLECT;
              end
            end else begin
              out_data  <= '0;
              out_cnt   <= '0;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              flush     <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= EMIT;
            end
          end else begin
            state <= COLLECT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            flush     <= 1'b0;
            state     <= flush ? FLUSH : COLLECT;
          end else begin
            state <= EMIT;
          end
        end
        FLUSH: begin
          if (accept && is_delim) begin
            state <= COLLECT;
          end else begin
            state <= FLUSH;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_hex_stream_parser.sv
// Bench for ascii_hex_stream_parser: three configurations share one input stream,
// each tracked by a word-level reference model checked every cycle, plus directed tables.
module tb_ascii_hex_stream_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;

  logic        ir_a, ov_a, oe_a, ir_b, ov_b, oe_b, ir_c, ov_c, oe_c;
  logic [15:0] od_a, od_b;
  logic [3:0]  od_c;
  logic [2:0]  oc_a, oc_b;
  logic [0:0]  oc_c;

  ascii_hex_stream_parser #(.NDIG(4), .ALLOW_LOWER(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_cnt(oc_a), .out_err(oe_a));
  ascii_hex_stream_parser #(.NDIG(4), .ALLOW_LOWER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_cnt(oc_b), .out_err(oe_b));
  ascii_hex_stream_parser #(.NDIG(1), .ALLOW_LOWER(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_cnt(oc_c), .out_err(oe_c));

  // Reference: a pending word (if any), whether we are skipping to a delimiter,
  // and the value/count of digits collected so far.
  typedef struct {
    bit          pv;
    logic [63:0] pd;
    int          pc;
    bit          pe;
    bit          fl;
    logic [63:0] val;
    int          n;
  } model_t;

  typedef struct {
    bit          v;
    bit          r;
    bit          e;
    logic [63:0] d;
    logic [63:0] c;
  } obs_t;

  typedef struct {
    logic [15:0] d;
    int          c;
    bit          e;
  } word_t;

  typedef struct {
    logic [63:0] s;
    int          len;
    int          nw;
    logic [15:0] d;
    int          c;
    bit          e;
  } vec_t;

  model_t m[3];
  int     ndig_of[3] = '{4, 4, 1};
  bit     lower_of[3] = '{1'b1, 1'b0, 1'b1};
  word_t  cap_a[$];
  word_t  cap_b[$];
  bit     run_chk = 1'b0;
  int     checks = 0;
  int     passes = 0;

  function automatic int digit_val(logic [7:0] ch, bit low);
    if (ch >= 8'h30 && ch <= 8'h39) return int'(ch) - 48;
    if (ch >= 8'h41 && ch <= 8'h46) return int'(ch) - 55;
    if (low && ch >= 8'h61 && ch <= 8'h66) return int'(ch) - 87;
    return -1;
  endfunction

  function automatic bit is_delim(logic [7:0] ch);
    return ch == 8'h0D || ch == 8'h0A || ch == 8'h20;
  endfunction

  function automatic model_t step(model_t s, logic r, logic iv, logic [7:0] ch,
                                  logic ordy, int nd, bit low);
    model_t t = s;
    int     dv;
    if (r) begin
      t.pv = 1'b0; t.pd = 64'd0; t.pc = 0; t.pe = 1'b0;
      t.fl = 1'b0; t.val = 64'd0; t.n = 0;
      return t;
    end
    if (t.pv) begin
      if (ordy) t.pv = 1'b0;
      return t;
    end
    if (!iv) return t;
    if (t.fl) begin
      if (is_delim(ch)) t.fl = 1'b0;
      return t;
    end
    dv = digit_val(ch, low);
    if (dv >= 0) begin
      t.val = t.val * 64'd16 + 64'(dv);
      t.n   = t.n + 1;
      if (t.n == nd) begin
        t.pv = 1'b1; t.pd = t.val; t.pc = t.n; t.pe = 1'b0;
        t.val = 64'd0; t.n = 0;
      end
    end else if (is_delim(ch)) begin
      if (t.n > 0) begin
        t.pv = 1'b1; t.pd = t.val; t.pc = t.n; t.pe = 1'b0;
        t.val = 64'd0; t.n = 0;
      end
    end else begin
      t.pv = 1'b1; t.pd = 64'd0; t.pc = 0; t.pe = 1'b1; t.fl = 1'b1;
      t.val = 64'd0; t.n = 0;
    end
    return t;
  endfunction

  function automatic obs_t obs(int i);
    obs_t o;
    case (i)
      0: begin o.v = ov_a; o.r = ir_a; o.e = oe_a; o.d = 64'(od_a); o.c = 64'(oc_a); end
      1: begin o.v = ov_b; o.r = ir_b; o.e = oe_b; o.d = 64'(od_b); o.c = 64'(oc_b); end
      default: begin o.v = ov_c; o.r = ir_c; o.e = oe_c; o.d = 64'(od_c); o.c = 64'(oc_c); end
    endcase
    return o;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      m[i] <= step(m[i], rst, in_valid, in_data, out_ready, ndig_of[i], lower_of[i]);
  end

  // Cycle-level comparison against the model, and capture of transferred words.
  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 3; i++) begin
        obs_t o;
        o = obs(i);
        chk($sformatf("dut%0d in_ready", i), 64'(o.r), 64'(!rst && !m[i].pv));
        chk($sformatf("dut%0d out_valid", i), 64'(o.v), 64'(m[i].pv));
        if (m[i].pv) begin
          chk($sformatf("dut%0d out_data", i), o.d, m[i].pd);
          chk($sformatf("dut%0d out_cnt", i), o.c, 64'(m[i].pc));
          chk($sformatf("dut%0d out_err", i), 64'(o.e), 64'(m[i].pe));
        end
      end
    end
    if (!rst && out_ready && ov_a) cap_a.push_back('{od_a, int'(oc_a), oe_a});
    if (!rst && out_ready && ov_b) cap_b.push_back('{od_b, int'(oc_b), oe_b});
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] ch, int idx);
    bit got = 1'b0;
    int k = 0;
    in_valid = 1'b1;
    in_data  = ch;
    while (!got && k < 100) begin
      @(negedge clk);
      got = obs(idx).r;
      @(posedge clk);
      #1;
      k++;
    end
    if (!got) chk($sformatf("send timeout dut%0d", idx), 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_str(logic [63:0] s, int len, int idx);
    for (int k = 0; k < len; k++) send(s[63-8*k -: 8], idx);
  endtask

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 9);
    int h = $urandom_range(0, 15);
    case (r)
      0, 1, 2, 3: return (h < 10) ? 8'(48 + h) : 8'(55 + h);
      4, 5:       return 8'(97 + $urandom_range(0, 5));
      6, 7: begin
        case ($urandom_range(0, 2))
          0:       return 8'h0D;
          1:       return 8'h0A;
          default: return 8'h20;
        endcase
      end
      8:       return 8'($urandom_range(0, 255));
      default: return 8'h47;
    endcase
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = '{64'h3141326600000000, 4, 1, 16'h1A2F, 4, 1'b0};
    tbl[1] = '{64'h0D00000000000000, 1, 0, 16'h0000, 0, 1'b0};
    tbl[2] = '{64'h37420D0000000000, 3, 1, 16'h007B, 2, 1'b0};
    tbl[3] = '{64'h200D0A0000000000, 3, 0, 16'h0000, 0, 1'b0};
    tbl[4] = '{64'h314733340D000000, 5, 1, 16'h0000, 0, 1'b1};
    tbl[5] = '{64'h4142434400000000, 4, 1, 16'hABCD, 4, 1'b0};

    rst = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;
    @(negedge clk);
    chk("reset out_valid", 64'(ov_a), 64'd0);
    chk("reset out_data", 64'(od_a), 64'd0);
    chk("reset out_cnt", 64'(oc_a), 64'd0);
    chk("reset out_err", 64'(oe_a), 64'd0);
    chk("reset in_ready", 64'(ir_a), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    for (int t = 0; t < 6; t++) begin
      cap_a.delete();
      send_str(tbl[t].s, tbl[t].len, 0);
      idle(4);
      chk($sformatf("tbl%0d words", t), 64'(cap_a.size()), 64'(tbl[t].nw));
      if (cap_a.size() > 0) begin
        chk($sformatf("tbl%0d data", t), 64'(cap_a[0].d), 64'(tbl[t].d));
        chk($sformatf("tbl%0d cnt", t), 64'(cap_a[0].c), 64'(tbl[t].c));
        chk($sformatf("tbl%0d err", t), 64'(cap_a[0].e), 64'(tbl[t].e));
      end
    end

    // Uppercase-only instance: 'a' errors, 'b' is flushed without a second error.
    cap_b.delete();
    send_str(64'h61620D0000000000, 3, 1);
    idle(4);
    chk("nolower words", 64'(cap_b.size()), 64'd1);
    if (cap_b.size() > 0) begin
      chk("nolower err", 64'(cap_b[0].e), 64'd1);
      chk("nolower cnt", 64'(cap_b[0].c), 64'd0);
    end

    // Stalled output for 10 cycles, then release.
    cap_a.delete();
    out_ready = 1'b0;
    send_str(64'h35450D0000000000, 3, 0);
    idle(10);
    chk("stall words", 64'(cap_a.size()), 64'd0);
    chk("stall out_valid", 64'(ov_a), 64'd1);
    chk("stall in_ready", 64'(ir_a), 64'd0);
    out_ready = 1'b1;
    idle(1);
    chk("release words", 64'(cap_a.size()), 64'd1);
    if (cap_a.size() > 0) chk("release data", 64'(cap_a[0].d), 64'h5E);
    chk("release in_ready", 64'(ir_a), 64'd1);

    // Reset mid-word, then reset during a stalled word.
    send_str(64'h3132000000000000, 2, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    out_ready = 1'b0;
    send_str(64'h390D000000000000, 2, 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk("rst2 out_valid", 64'(ov_a), 64'd0);
    chk("rst2 out_data", 64'(od_a), 64'd0);
    chk("rst2 out_cnt", 64'(oc_a), 64'd0);
    chk("rst2 out_err", 64'(oe_a), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    cap_a.delete();
    send_str(64'h3334353600000000, 4, 0);
    idle(4);
    chk("post-reset words", 64'(cap_a.size()), 64'd1);
    if (cap_a.size() > 0) begin
      chk("post-reset data", 64'(cap_a[0].d), 64'h3456);
      chk("post-reset cnt", 64'(cap_a[0].c), 64'd4);
    end

    // Random traffic; the per-cycle model comparison does the checking.
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_char();
      out_ready = (k >= 2000 && k < 2500) ? ($urandom_range(0, 7) == 0)
                                          : ($urandom_range(0, 3) != 0);
      idle(1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
